// File: rtl/bram_stream_pkg.sv
// Shared definitions for the BRAM stream reader: controller state encoding
// and output FIFO sizing.
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 4;
    // Count must represent 0..FIFO_DEPTH inclusive.
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_stream_fifo.sv
// Small output FIFO for the BRAM stream reader. The caller guarantees it never
// writes when full or reads when empty (credit-based issue upstream).
// Head data reads as zero while empty so the stream bus is quiet after reset.
module bram_stream_fifo
    import bram_stream_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    output logic [data_width-1:0] rd_data,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [data_width-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage array; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a 1-cycle-latency BRAM and streams
// them out through a valid/ready interface, buffered by a 4-entry FIFO.
// Reads are only issued while buffered plus in-flight words fit in the FIFO,
// so backpressure never drops RAM data.
// Optional macro BRAM_STREAM_READER_LAST_EN adds out_last on the final word.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int data_width = 16,
    parameter int addr_width = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   length,
    output logic [addr_width-1:0] raddr,
    output logic                  read_en,
    input  logic [data_width-1:0] rdata,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
`ifdef BRAM_STREAM_READER_LAST_EN
    output logic                  out_last,
`endif
    output logic                  done
);

    localparam int                OCC_W = CNT_W + 1;
    localparam logic [addr_width:0] ONE = 1;

    state_t                state, state_nxt;
    logic [addr_width-1:0] ptr;
    logic [addr_width:0]   rem_issue;
    logic [addr_width:0]   rem_xfer;
    logic                  rd_pipe;     // rdata is valid this cycle
    logic                  zero_done;   // pulse for an empty burst
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occ_nxt;
    logic                  accept, issue, last_xfer, pop;

    assign pop = out_valid & out_ready;

    // Next-cycle commitment = next FIFO count plus the read currently on the
    // RAM port; a new read may be registered only if that leaves room.
    assign occ_nxt = OCC_W'(fifo_count) + OCC_W'(rd_pipe) - OCC_W'(pop)
                   + OCC_W'(read_en);

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        last_xfer = 1'b0;
        case (state)
            IDLE: begin
                if (start && length != '0) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (occ_nxt < OCC_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (rem_issue == ONE) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && rem_xfer == ONE) begin
                    last_xfer = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered RAM port, burst counters and address pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            raddr     <= '0;
            read_en   <= 1'b0;
            rd_pipe   <= 1'b0;
            zero_done <= 1'b0;
            ptr       <= '0;
            rem_issue <= '0;
            rem_xfer  <= '0;
        end else begin
            state     <= state_nxt;
            read_en   <= issue;
            rd_pipe   <= read_en;
            zero_done <= (state == IDLE) && start && (length == '0);
            if (accept) begin
                ptr       <= base_addr;
                rem_issue <= length;
                rem_xfer  <= length;
            end
            if (issue) begin
                raddr     <= ptr;
                ptr       <= ptr + 1'b1;
                rem_issue <= rem_issue - 1'b1;
            end
            if (pop) rem_xfer <= rem_xfer - 1'b1;
        end
    end

    bram_stream_fifo #(.data_width(data_width)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rd_pipe),
        .wr_data (rdata),
        .rd_en   (pop),
        .rd_data (out_data),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign busy      = (state != IDLE);
    assign done      = last_xfer | zero_done;

`ifdef BRAM_STREAM_READER_LAST_EN
    assign out_last  = out_valid && busy && (rem_xfer == ONE);
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a RAM model with one-cycle read
// latency, a scoreboard queue of expected words, and one task per scenario.
// With BRAM_STREAM_READER_LAST_EN defined, out_last is also checked.
module tb_bram_stream_reader;

    localparam int DW = 16;
    localparam int AW = 10;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] raddr;
    logic          read_en;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
`ifdef BRAM_STREAM_READER_LAST_EN
    logic          out_last;
`endif

    logic [DW-1:0] mem [1 << AW];
    exp_t          exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_issued = 0;
    int            n_xfer = 0;
    bit            rand_ready = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data = '0;

    bram_stream_reader #(.data_width(DW), .addr_width(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .raddr     (raddr),
        .read_en   (read_en),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef BRAM_STREAM_READER_LAST_EN
        .out_last  (out_last),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // RAM model: data appears the cycle after a read_en cycle.
    always @(posedge clk) begin
        if (read_en) rdata <= mem[raddr];
    end

    // Random backpressure, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                n_cmp++;
                if (!out_valid || out_data !== prev_data) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h",
                             out_valid, out_data, prev_data);
                end
            end
            if (read_en) begin
                n_cmp++;
                if (n_issued - n_xfer >= 4) begin
                    n_err++;
                    $display("FAIL credit: read_en with %0d outstanding, required < 4",
                             n_issued - n_xfer);
                end
                n_issued++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: got %h, required no transfer", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data) begin
                        n_err++;
                        $display("FAIL data: got %h required %h", out_data, e.data);
                    end
`ifdef BRAM_STREAM_READER_LAST_EN
                    n_cmp++;
                    if (out_last !== e.last) begin
                        n_err++;
                        $display("FAIL out_last: got %0b required %0b", out_last, e.last);
                    end
`endif
                end
                n_xfer++;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Present a start for one cycle; returns just after the accept edge with
    // the inputs scrambled to show they were latched.
    task automatic do_start(input logic [AW-1:0] b, input int len);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        length    = (AW+1)'(len);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.data = mem[AW'(b + AW'(i))];
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = (AW+1)'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: done not seen in %0d cycles", name, budget);
        end
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: %0d words left busy=%0b, required 0 and 0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({read_en, out_valid, busy, done} !== 4'b0 || raddr !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset: re=%0b ov=%0b busy=%0b done=%0b raddr=%h od=%h, required all 0",
                     read_en, out_valid, busy, done, raddr, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        do_start(10'd0, 8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic_latency: edge %0d valid=%0b busy=%0b, required 0 and 1",
                         k, out_valid, busy);
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || done !== (k == 7)) begin
                n_err++;
                $display("FAIL basic_stream: word %0d valid=%0b done=%0b, required 1 and %0b",
                         k, out_valid, done, (k == 7));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_end: valid=%0b busy=%0b done=%0b left=%0d, required 0 0 0 0",
                     out_valid, busy, done, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        do_start(10'd1020, 6);
        wait_done("wrap", 50);
        check_drained("wrap");
    endtask

    task automatic test_backpressure();
        rand_ready = 1'b1;
        do_start(10'd100, 16);
        wait_done("backpressure", 500);
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        check_drained("backpressure");
    endtask

    task automatic test_empty();
        int issued0;
        issued0 = n_issued;
        do_start(10'd5, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL empty_done: done=%0b busy=%0b, required 1 and 0", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || n_issued != issued0) begin
            n_err++;
            $display("FAIL empty_after: done=%0b busy=%0b reads=%0d, required 0 0 0",
                     done, busy, n_issued - issued0);
        end
    endtask

    task automatic test_reset_mid();
        do_start(10'd200, 32);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || read_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: valid=%0b re=%0b busy=%0b, required all 0",
                     out_valid, read_en, busy);
        end
        exp_q.delete();
        n_issued = 0;
        n_xfer   = 0;
        do_start(10'd300, 4);
        wait_done("reset_mid", 50);
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        do_start(10'd500, 3);
        wait_done("b2b_first", 50);
        do_start(10'd700, 5);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%0b required 1", busy);
        end
        wait_done("b2b_second", 50);
        check_drained("b2b");
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        do_start(10'd0, 1024);
        wait_done("full", 1200);
        check_drained("full");
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = DW'((i * 40503) ^ (i >> 3) ^ 16'h5A3C);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        test_full();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter data_width, default 16, the RAM word width.
REQ-002 SHALL have parameter addr_width, default 10, the RAM address width (1024 words).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  addr_width  first RAM address of the burst.
REQ-007 SHALL have port length  input  addr_width+1  number of words to read, 0..2^addr_width.
REQ-008 SHALL have port raddr  output  addr_width  RAM read address.
REQ-009 SHALL have port read_en  output  1  RAM read enable.
REQ-010 SHALL have port rdata  input  data_width  RAM dout, valid the cycle after a read_en cycle.
REQ-011 SHALL have port out_data  output  data_width  stream data.
REQ-012 SHALL have port out_valid  output  1  stream valid.
REQ-013 SHALL have port out_ready  input  1  stream ready; a transfer occurs when out_valid and out_ready are both high.
REQ-014 SHALL have port busy  output  1  high outside IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the last word of a burst has transferred.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN: IDLE->ISSUE on start with length>0; ISSUE->DRAIN after the last read_en; DRAIN->IDLE when the last word transfers.
REQ-017 SHALL treat start with length==0 as an empty burst: no read_en, done pulsed the following cycle, stays IDLE.
REQ-018 SHALL ignore start while busy is high.
REQ-019 SHALL latch base_addr and length on the accepted start; later input changes have no effect on the burst.
REQ-020 SHALL issue reads at base_addr, base_addr+1, ..., incrementing raddr modulo 2^addr_width (1023 wraps to 0).
REQ-021 SHALL hold an internal 4-entry output FIFO; read_en asserted only while (fifo_count + reads_in_flight) < 4, so no RAM data is lost under backpressure.
REQ-022 SHALL write rdata into the FIFO on the cycle after each read_en cycle; out_data/out_valid driven from the FIFO head.
REQ-023 SHALL produce first out_valid 3 cycles after the start-accept edge, sustaining 1 word/cycle with out_ready held high.
REQ-024 SHALL keep out_data stable while out_valid is high and out_ready is low.
REQ-025 SHALL emit exactly length words in address order, with no duplicates or drops.
REQ-026 SHALL allow start to be accepted in the cycle after done (back-to-back bursts).

Reset
REQ-027 SHALL, while rst_n low at a clock edge, clear state to IDLE, FIFO and in-flight counts to 0, and drive read_en=0, out_valid=0, busy=0, done=0, raddr=0, out_data=0.
REQ-028 SHALL abandon any in-progress burst on reset mid-operation; rdata arriving after reset is discarded.

Configuration
REQ-029 SHALL, with macro BRAM_STREAM_READER_LAST_EN defined, add output out_last (1 bit), high with the final word of each burst and 0 at reset.
REQ-030 SHALL, without BRAM_STREAM_READER_LAST_EN, omit out_last, with all other behaviour identical.

Structure
REQ-031 SHALL place the state encoding (IDLE, ISSUE, DRAIN) and the FIFO depth constant (4) in shared package bram_stream_pkg.
REQ-032 SHALL implement the output FIFO as sub-module bram_stream_fifo (4 entries, data_width wide, count output).

Verification
REQ-033 SHALL cover: base_addr=0, length=8, out_ready=1 -> words mem[0..7] on 8 consecutive cycles starting 3 cycles after start, done on the 8th transfer.
REQ-034 SHALL cover: base_addr=1020, length=6 -> words mem[1020..1023], mem[0], mem[1] in order.
REQ-035 SHALL cover: length=16 with out_ready toggling randomly 50% -> all 16 words in order, read_en never issued while fifo_count+in_flight==4.
REQ-036 SHALL cover: start with length=0 -> no read_en, done one cycle later, busy stays 0.
REQ-037 SHALL cover: rst_n low for 1 cycle mid-burst of length=32 -> next cycle out_valid=0, read_en=0, busy=0; a new burst of length=4 returns correct data.
REQ-038 SHALL cover: length=1024, base_addr=0 with LAST_EN defined -> 1024 words, out_last high only on word 1023.
